// File: rtl/darkroom_frame_scheduler_pkg.sv
// Shared constants, state encoding and frame types for the darkroom frame scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package darkroom_pkg;
  localparam int FRAME_BITS        = 256;
  localparam int SENSORS_PER_FRAME = 8;
  localparam int SENSOR_WORD_BITS  = 32;
  localparam int FRAME_ID_BITS     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_START,
    ST_WAIT_END,
    ST_GAP
  } state_t;

  typedef logic [FRAME_BITS-1:0]    frame_t;
  typedef logic [FRAME_ID_BITS-1:0] frame_id_t;
endpackage

// File: rtl/darkroom_frame_scheduler_if.sv
// SPI-side link between the frame scheduler (master) and SpiControl_esp8266 (slave).
// Latency: wires only.
// Backpressure: slave paces the master through ss_n_i start/end edges.
interface darkroom_frame_scheduler_if;
  import darkroom_pkg::*;

  logic      ss_n_i;
  logic      data_ready_o;
  frame_t    frame_o;
  frame_id_t frame_id_o;

  modport master (input ss_n_i, output data_ready_o, output frame_o, output frame_id_o);
  modport slave  (output ss_n_i, input data_ready_o, input frame_o, input frame_id_o);
endinterface

// File: rtl/darkroom_frame_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request after i_ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; caller decides when to consume the grant.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_grant,
  output logic          o_valid
);
  logic [IW-1:0] w_idx;

  // Scan ptr+1, ptr+2, ... and keep the first requester found.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/darkroom_frame_scheduler.sv
// Tracks pending sensor frames, grants the SPI link round-robin and paces each transfer.
// Latency: sync pulse at cycle N -> data_ready_o at N+4 when idle.
// Backpressure: waits on ss_n_i start/end edges; start timeout, then fixed inter-frame gap.
module darkroom_frame_scheduler
  import darkroom_pkg::*;
#(
  parameter int NUMBER_OF_FRAMES = 2,
  parameter int GAP_CYCLES       = 1024,
  parameter int START_TIMEOUT    = 4096
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUMBER_OF_FRAMES*SENSORS_PER_FRAME-1:0] sync_i,
  input  logic                                   trigger_me,
  input  logic [NUMBER_OF_FRAMES*FRAME_BITS-1:0] frame_data_i,
  darkroom_frame_scheduler_if.master             spi,
  output logic                                   busy_o,
  output logic [NUMBER_OF_FRAMES-1:0]            pending_o,
  output logic [15:0]                            coalesced_o,
  output logic                                   timeout_o
);
  localparam int IW = (NUMBER_OF_FRAMES > 1) ? $clog2(NUMBER_OF_FRAMES) : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t                      r_state, w_next;
  logic                        r_ss_prev;
  logic                        w_start_edge, w_end_edge;
  logic [NUMBER_OF_FRAMES-1:0] r_pending, w_set, w_clr;
  logic                        w_hit;
  logic [IW-1:0]               r_rr_ptr, r_grant, w_arb_grant;
  logic                        w_arb_vld;
  logic [TW-1:0]               r_tcnt;
  logic [GW-1:0]               r_gcnt;
  frame_t                      r_frame;
  frame_id_t                   r_frame_id;
  logic [15:0]                 r_coalesced;
  logic                        r_timeout;

  assign w_start_edge = r_ss_prev & ~spi.ss_n_i;
  assign w_end_edge   = ~r_ss_prev & spi.ss_n_i;

  rr_arbiter #(.N(NUMBER_OF_FRAMES), .IW(IW)) u_arb (
    .i_req   (r_pending),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_vld)
  );

  // Per-frame set/clear requests and whether any set lands on an already-pending frame.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int f = 0; f < NUMBER_OF_FRAMES; f++)
      w_set[f] = (|sync_i[f*SENSORS_PER_FRAME +: SENSORS_PER_FRAME]) | trigger_me;
    if (r_state == ST_LOAD)
      w_clr[r_grant] = 1'b1;
    w_hit = |(w_set & r_pending & ~w_clr);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (|r_pending) w_next = ST_ARB;
      ST_ARB:        w_next = w_arb_vld ? ST_LOAD : ST_IDLE;
      ST_LOAD:       w_next = ST_SEND;
      ST_SEND:       w_next = ST_WAIT_START;
      ST_WAIT_START: begin
        if (w_start_edge)                          w_next = ST_WAIT_END;
        else if (r_tcnt == TW'(START_TIMEOUT - 1)) w_next = ST_GAP;
      end
      ST_WAIT_END:   if (w_end_edge) w_next = ST_GAP;
      ST_GAP:        if (r_gcnt == '0) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; data_ready_o is a single SEND-cycle strobe.
  always_comb begin
    spi.data_ready_o = (r_state == ST_SEND);
    busy_o           = (r_state != ST_IDLE);
  end

  // Pending flags, coalesce counter, grant snapshot and pacing counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ss_prev   <= 1'b1;
      r_pending   <= '0;
      r_coalesced <= '0;
      r_rr_ptr    <= IW'(NUMBER_OF_FRAMES - 1);
      r_grant     <= '0;
      r_frame     <= '0;
      r_frame_id  <= '0;
      r_tcnt      <= '0;
      r_gcnt      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_ss_prev <= spi.ss_n_i;
      // Set has priority so a sync landing on LOAD keeps the frame queued.
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_hit && r_coalesced != 16'hFFFF)
        r_coalesced <= r_coalesced + 16'd1;
      case (r_state)
        ST_ARB:  r_grant <= w_arb_grant;
        ST_LOAD: begin
          r_frame    <= frame_data_i[r_grant*FRAME_BITS +: FRAME_BITS];
          r_frame_id <= FRAME_ID_BITS'(r_grant);
          r_rr_ptr   <= r_grant;
        end
        // Counter tracks clocks elapsed since the data_ready_o strobe.
        ST_SEND: r_tcnt <= TW'(1);
        ST_WAIT_START: begin
          r_tcnt <= r_tcnt + TW'(1);
          if (!w_start_edge && r_tcnt == TW'(START_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_gcnt    <= GW'(GAP_CYCLES - 1);
          end
        end
        ST_WAIT_END: if (w_end_edge) r_gcnt <= GW'(GAP_CYCLES - 1);
        ST_GAP:      if (r_gcnt != '0) r_gcnt <= r_gcnt - GW'(1);
        default: ;
      endcase
    end
  end

  assign spi.frame_o    = r_frame;
  assign spi.frame_id_o = r_frame_id;
  assign pending_o      = r_pending;
  assign coalesced_o    = r_coalesced;
  assign timeout_o      = r_timeout;
endmodule

// File: tb/tb_darkroom_frame_scheduler.sv
// Scoreboarded bench: stimulus pushes expected grants from a round-robin model, a monitor pops on data_ready_o.
// Latency: checks the N+4 request latency, GAP+1 idle return and START_TIMEOUT expiry.
// Backpressure: emulates the SPI slave by driving ss_n_i start/end edges.
module tb_darkroom_frame_scheduler;
  import darkroom_pkg::*;

  localparam int NF  = 3;
  localparam int GAP = 8;
  localparam int TO  = 40;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic [NF*8-1:0]          sync_i = '0;
  logic                     trigger_me = 1'b0;
  logic [NF*FRAME_BITS-1:0] frame_data_i = '0;
  logic                     busy_o;
  logic [NF-1:0]            pending_o;
  logic [15:0]              coalesced_o;
  logic                     timeout_o;

  darkroom_frame_scheduler_if spi_if();

  darkroom_frame_scheduler #(
    .NUMBER_OF_FRAMES (NF),
    .GAP_CYCLES       (GAP),
    .START_TIMEOUT    (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sync_i       (sync_i),
    .trigger_me   (trigger_me),
    .frame_data_i (frame_data_i),
    .spi          (spi_if),
    .busy_o       (busy_o),
    .pending_o    (pending_o),
    .coalesced_o  (coalesced_o),
    .timeout_o    (timeout_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           id;
    logic [255:0] data;
  } exp_t;

  int            total = 0;
  int            bad   = 0;
  exp_t          exp_q[$];
  logic [NF-1:0] m_pend;
  int            m_rr;
  int            m_coal;
  logic          prev_dr = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every data_ready_o strobe must match the oldest scheduled grant.
  always @(negedge clock) begin
    if (!reset && spi_if.data_ready_o) begin
      check("dr_single_cycle", prev_dr, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_send: id %0d sent with nothing scheduled", spi_if.frame_id_o);
      end else begin
        check("sb_frame_id", spi_if.frame_id_o, exp_q[0].id);
        check("sb_frame_data", spi_if.frame_o, exp_q[0].data);
        exp_q.delete(0);
      end
    end
    prev_dr <= reset ? 1'b0 : spi_if.data_ready_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_rr   = NF - 1;
    m_coal = 0;
    exp_q.delete();
  endtask

  // Any frame whose sensors pulse (or all, on trigger) becomes pending; hits on pending frames coalesce.
  task automatic model_set(input logic [NF*8-1:0] s, input logic trig);
    logic [NF-1:0] set;
    for (int f = 0; f < NF; f++) set[f] = (|s[f*8 +: 8]) | trig;
    if ((set & m_pend) != '0 && m_coal < 65535) m_coal++;
    m_pend |= set;
  endtask

  // Schedule the next frame the link should carry: first pending after the last grant.
  task automatic push_next();
    int   g;
    exp_t e;
    if (m_pend == '0) return;
    g = m_rr;
    do g = (g + 1) % NF; while (!m_pend[g]);
    e.id   = g;
    e.data = frame_data_i[g*FRAME_BITS +: FRAME_BITS];
    exp_q.push_back(e);
    m_rr      = g;
    m_pend[g] = 1'b0;
  endtask

  task automatic pulse(input logic [NF*8-1:0] s, input logic trig);
    sync_i     = s;
    trigger_me = trig;
    model_set(s, trig);
    step();
    sync_i     = '0;
    trigger_me = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spi_if.ss_n_i = 1'b1;
    model_reset();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic rand_data();
    for (int w = 0; w < NF*8; w++) frame_data_i[w*32 +: 32] = $urandom();
  endtask

  function automatic logic [NF*8-1:0] rand_sync();
    logic [NF*8-1:0] v;
    v = '0;
    v[$urandom_range(NF*8-1)] = 1'b1;
    if ($urandom_range(3) == 0) v[$urandom_range(NF*8-1)] = 1'b1;
    return v;
  endfunction

  // Returns at posedge+1 of the cycle after data_ready_o; k counts negedges waited.
  task automatic wait_ready(output int k);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!spi_if.data_ready_o && k < 300);
    if (!spi_if.data_ready_o) begin
      total++;
      bad++;
      $display("FAIL wait_ready: no data_ready_o within %0d clocks", k);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(output int j);
    j = 0;
    while (busy_o && j < 300) begin
      step();
      j++;
    end
    if (busy_o) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy_o still high after %0d clocks", j);
    end
  endtask

  task automatic serve_check(input int id);
    int k;
    wait_ready(k);
    check("grant_id", spi_if.frame_id_o, id);
  endtask

  // Slave side of one transfer: ss_n_i low for `hold` clocks, then high (end edge) and schedule the next grant.
  task automatic spi_xfer(input int hold, input bit rnd);
    spi_if.ss_n_i = 1'b0;
    for (int c = 0; c < hold; c++) begin
      if (rnd && $urandom_range(2) == 0) pulse(rand_sync(), $urandom_range(9) == 0);
      else step();
    end
    spi_if.ss_n_i = 1'b1;
    push_next();
  endtask

  initial begin
    int k;
    int j;
    spi_if.ss_n_i = 1'b1;
    model_reset();
    step();
    step();
    check("rst_data_ready", spi_if.data_ready_o, 1'b0);
    check("rst_frame", spi_if.frame_o, '0);
    check("rst_frame_id", spi_if.frame_id_o, '0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_pending", pending_o, '0);
    check("rst_coalesced", coalesced_o, '0);
    check("rst_timeout", timeout_o, 1'b0);
    reset = 1'b0;
    step();

    // Single sync on frame 0 sensor 3.
    rand_data();
    pulse(24'h000008, 1'b0);
    push_next();
    wait_ready(k);
    check("latency", k, 4);
    check("dr_dropped", spi_if.data_ready_o, 1'b0);
    check("frame0_id", spi_if.frame_id_o, 0);
    check("frame0_data", spi_if.frame_o, frame_data_i[255:0]);
    check("pend_after_load", pending_o, 3'b000);
    spi_xfer(100, 1'b0);
    check("busy_wait_end", busy_o, 1'b1);
    wait_idle(j);
    check("gap_len", j, GAP + 1);

    // Round-robin from reset with all frames triggered, then re-pend 0 and 2 during frame 2.
    do_reset();
    rand_data();
    pulse('0, 1'b1);
    push_next();
    serve_check(0);
    check("rr_pending", pending_o, 3'b110);
    spi_xfer(3, 1'b0);
    serve_check(1);
    spi_xfer(3, 1'b0);
    serve_check(2);
    spi_if.ss_n_i = 1'b0;
    step();
    pulse(24'h010001, 1'b0);
    step();
    spi_if.ss_n_i = 1'b1;
    push_next();
    serve_check(0);
    spi_xfer(2, 1'b0);
    serve_check(2);
    spi_xfer(2, 1'b0);
    wait_idle(j);

    // Coalescing: five pulses on frame 1 while frame 0 holds the link.
    do_reset();
    rand_data();
    pulse(24'h000008, 1'b0);
    push_next();
    serve_check(0);
    spi_if.ss_n_i = 1'b0;
    step();
    for (int p = 0; p < 5; p++) begin
      pulse(24'h000200, 1'b0);
      step();
    end
    check("coalesced_4", coalesced_o, 16'd4);
    check("coal_pending", pending_o, 3'b010);
    spi_if.ss_n_i = 1'b1;
    push_next();
    serve_check(1);
    spi_xfer(2, 1'b0);
    wait_idle(j);
    check("coal_single_tx", exp_q.size(), 0);

    // Set/clear collision: frame 1 sync lands on its own LOAD cycle.
    do_reset();
    rand_data();
    pulse(24'h000100, 1'b0);
    push_next();
    step();
    step();
    sync_i = 24'h000100;
    m_pend[1] = 1'b1;
    step();
    sync_i = '0;
    wait_ready(k);
    check("collide_latency", k, 1);
    check("collide_pending", pending_o, 3'b010);
    check("collide_no_coal", coalesced_o, 16'd0);
    spi_xfer(2, 1'b0);
    serve_check(1);
    spi_xfer(2, 1'b0);
    wait_idle(j);

    // Start timeout with no ss_n_i activity.
    do_reset();
    rand_data();
    pulse(24'h010000, 1'b0);
    push_next();
    wait_ready(k);
    j = 1;
    while (!timeout_o && j < TO + 50) begin
      step();
      j++;
    end
    check("timeout_at", j, TO);
    check("timeout_busy", busy_o, 1'b1);
    check("timeout_not_requeued", pending_o, 3'b000);
    wait_idle(j);
    check("timeout_gap", j, GAP);
    pulse(24'h000001, 1'b0);
    push_next();
    serve_check(0);
    spi_xfer(3, 1'b0);
    wait_idle(j);
    check("timeout_sticky", timeout_o, 1'b1);

    // Asynchronous reset during WAIT_END.
    do_reset();
    rand_data();
    pulse(24'h000100, 1'b0);
    push_next();
    wait_ready(k);
    spi_if.ss_n_i = 1'b0;
    step();
    pulse(24'h010000, 1'b0);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_data_ready", spi_if.data_ready_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_pending", pending_o, '0);
    check("arst_coalesced", coalesced_o, '0);
    check("arst_frame", spi_if.frame_o, '0);
    check("arst_frame_id", spi_if.frame_id_o, '0);
    model_reset();
    spi_if.ss_n_i = 1'b1;
    step();
    reset = 1'b0;
    repeat (30) step();
    check("arst_quiet_busy", busy_o, 1'b0);

    // Randomised traffic against the model.
    do_reset();
    rand_data();
    for (int it = 0; it < 30; it++) begin
      if (exp_q.size() == 0) begin
        wait_idle(j);
        pulse(rand_sync(), $urandom_range(7) == 0);
        push_next();
      end
      wait_ready(k);
      check("rnd_pending", pending_o, m_pend);
      check("rnd_coalesced", coalesced_o, 16'(m_coal));
      rand_data();
      repeat ($urandom_range(5)) step();
      spi_xfer($urandom_range(12, 1), 1'b1);
    end
    wait_idle(j);

    // Coalesce counter saturation: hold frame 1 sync while frame 0 occupies the link.
    do_reset();
    rand_data();
    pulse(24'h000001, 1'b0);
    push_next();
    serve_check(0);
    spi_if.ss_n_i = 1'b0;
    sync_i = 24'h000200;
    while (m_coal < 16'hFFFE) begin
      model_set(sync_i, 1'b0);
      step();
    end
    check("coal_fffe", coalesced_o, 16'hFFFE);
    repeat (3) begin
      model_set(sync_i, 1'b0);
      step();
    end
    sync_i = '0;
    check("coal_sat", coalesced_o, 16'hFFFF);
    spi_if.ss_n_i = 1'b1;
    push_next();
    serve_check(1);
    spi_xfer(2, 1'b0);
    wait_idle(j);

    repeat (5) step();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
